// File: rtl/rf_pkg.sv
// rf_pkg: shared types, helpers and constants for the multiport register file
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    localparam int RF_ZERO_ADDR = 0;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear/flush sequencer that walks every entry to zero and then raises ready
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    // next state: step the pointer while clearing, restart on a flush request once ready
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == RF_CLEAR) begin
            ptr_d   = ptr_q + AW'(1);
            state_d = (ptr_q == AW'(DEPTH - 1)) ? RF_READY : RF_CLEAR;
        end else if (clr_req) begin
            ptr_d   = '0;
            state_d = RF_CLEAR;
        end
    end

    // state and pointer registers; reset restarts the clear from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ready    = (state_q == RF_READY);
    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: N-read / M-write register file with zero register and clear engine (optional RF_WRITE_BYPASS_EN)
module rf_multiport
    import rf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 3,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_req,
    output logic                      ready,
    input  logic [NWRITE-1:0]         we,
    input  logic [NWRITE*rf_aw(DEPTH)-1:0] waddr,
    input  logic [NWRITE*WIDTH-1:0]   wdata,
    input  logic [NREAD*rf_aw(DEPTH)-1:0]  raddr,
    output logic [NREAD*WIDTH-1:0]    rdata
);

    localparam int AW = rf_aw(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic [NWRITE-1:0] wr_en;

    rf_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // a flush request in the same cycle drops all port writes
    assign wr_en = we & {NWRITE{ready & ~clr_req}};

    // storage update: clear engine first, then ports in ascending order so the highest port wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                mem_q[clr_addr] <= '0;
            for (int k = 0; k < NWRITE; k++)
                if (wr_en[k] && !(ZERO_REG != 0 && waddr[k*AW +: AW] == AW'(RF_ZERO_ADDR)))
                    mem_q[waddr[k*AW +: AW]] <= wdata[k*WIDTH +: WIDTH];
        end
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] val;
        assign ra = raddr[j*AW +: AW];
        // stored word, optionally overridden by the highest matching same-cycle write
        always_comb begin
            val = mem_q[ra];
`ifdef RF_WRITE_BYPASS_EN
            for (int k = 0; k < NWRITE; k++)
                if (wr_en[k] && waddr[k*AW +: AW] == ra)
                    val = wdata[k*WIDTH +: WIDTH];
`endif
        end
        assign rdata[j*WIDTH +: WIDTH] =
            (!ready || (ZERO_REG != 0 && ra == AW'(RF_ZERO_ADDR))) ? '0 : val;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: vector table plus scoreboard checks for reset, writes, conflicts, bypass and flush
module tb_rf_multiport;
    localparam int W = 32, D = 32, AW = 5, NR = 3, NW = 2;

    logic              clk = 1'b0;
    logic              rst, clr_req, ready;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*W-1:0]   wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*W-1:0]   rdata;

    int errors = 0, checks = 0;
    logic [W-1:0] sb_q[$];

    typedef struct {
        logic [1:0]    we;
        logic [4:0]    wa0;
        logic [31:0]   wd0;
        logic [4:0]    wa1;
        logic [31:0]   wd1;
        logic [14:0]   ra;
        logic [95:0]   ex;
    } vec_t;

    vec_t vecs[7];

    rf_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e;
        vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        {5'd5, 5'd5, 5'd5},   {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}};
        vecs[1] = '{2'b01, 5'd0,  32'h00001234, 5'd0,  32'h0,        {5'd0, 5'd5, 5'd0},   {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[2] = '{2'b11, 5'd7,  32'h00000011, 5'd7,  32'h00000022, {5'd0, 5'd5, 5'd7},   {32'h0, 32'hDEADBEEF, 32'h22}};
        vecs[3] = '{2'b10, 5'd0,  32'h0,        5'd31, 32'hCAFEF00D, {5'd5, 5'd7, 5'd31},  {32'hDEADBEEF, 32'h22, 32'hCAFEF00D}};
        vecs[4] = '{2'b11, 5'd1,  32'h0000AAAA, 5'd2,  32'h0000BBBB, {5'd31, 5'd2, 5'd1},  {32'hCAFEF00D, 32'hBBBB, 32'hAAAA}};
        vecs[5] = '{2'b00, 5'd1,  32'h0000FFFF, 5'd3,  32'h0000FFFF, {5'd3, 5'd2, 5'd1},   {32'h0, 32'hBBBB, 32'hAAAA}};
        vecs[6] = '{2'b10, 5'd0,  32'h0,        5'd0,  32'h00000009, {5'd0, 5'd0, 5'd0},   {32'h0, 32'h0, 32'h0}};

        rst = 1'b1; clr_req = 1'b0; we = '0; waddr = '0; wdata = '0;
        raddr = {5'd3, 5'd2, 5'd1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("init_ready_e%0d", i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
            if (i < 32)
                for (int j = 0; j < NR; j++)
                    chk($sformatf("init_rd%0d_e%0d", j, i), rdata[j*W +: W], 32'h0);
        end

        for (int i = 0; i < 7; i++) begin
            we    = vecs[i].we;
            waddr = {vecs[i].wa1, vecs[i].wa0};
            wdata = {vecs[i].wd1, vecs[i].wd0};
            raddr = vecs[i].ra;
            for (int j = 0; j < NR; j++) sb_q.push_back(vecs[i].ex[j*W +: W]);
            tick();
            we = '0;
            #1;
            for (int j = 0; j < NR; j++) begin
                e = sb_q.pop_front();
                chk($sformatf("vec%0d_rd%0d", i, j), rdata[j*W +: W], e);
            end
        end

        raddr = {5'd0, 5'd0, 5'd9};
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hA5A5A5A5};
        #1;
`ifdef RF_WRITE_BYPASS_EN
        chk("bypass_same_cycle", rdata[0 +: W], 32'hA5A5A5A5);
`else
        chk("bypass_same_cycle", rdata[0 +: W], 32'h0);
`endif
        tick();
        we = '0;
        #1;
        chk("bypass_after_edge", rdata[0 +: W], 32'hA5A5A5A5);
        raddr = {5'd0, 5'd0, 5'd0};
        we = 2'b10; waddr = {5'd0, 5'd9}; wdata = {32'h55, 32'h0};
        #1;
        chk("bypass_zero_reg", rdata[0 +: W], 32'h0);
        tick();
        we = '0;

        for (int r = 1; r < 32; r++) begin
            we = 2'b01; waddr = {5'd0, 5'(r)}; wdata = {32'h0, r * 32'h01010101 + 32'h10};
            tick();
        end
        we = '0; raddr = {5'd31, 5'd1, 5'd3};
        #1;
        chk("fill_r3", rdata[0 +: W], 32'h03030313);
        chk("fill_r31", rdata[2*W +: W], 32'h1F1F1F2F);
        clr_req = 1'b1; we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h77};
        tick();
        clr_req = 1'b0; we = '0;
        #1;
        chk("flush_ready_low", {31'b0, ready}, 32'd0);
        chk("flush_rd_in_clear", rdata[0 +: W], 32'h0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("flush_ready_e%0d", i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        for (int r = 0; r < 32; r++) begin
            raddr = {5'd0, 5'd0, 5'(r)};
            #1;
            chk($sformatf("flush_r%0d", r), rdata[0 +: W], 32'h0);
        end

        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h44};
        tick();
        we = '0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("midclr_ready_low", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("midclr_ready_e%0d", i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        raddr = {5'd0, 5'd0, 5'd4};
        #1;
        chk("midclr_r4", rdata[0 +: W], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
